sokoban_game_ctrl_p: RTL and testbench

Parametrised top-level game sequencer for the Sokoban core. It owns the stage index, step counter and undo-depth bookkeeping that were previously external. It arbitrates player commands (move / retry / undo) against a move-evaluation engine through a req/done handshake. It drives the game-state register load enable and mux select, and detects stage clear and game completion.

---
 rtl/sokoban_pkg.sv | 32 +++
 rtl/sokoban_game_ctrl_p_if.sv | 12 +
 rtl/sokoban_sat_counter.sv | 30 +++
 rtl/sokoban_game_ctrl_p.sv | 141 ++++++++++++++
 tb/tb_sokoban_game_ctrl_p.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sokoban_pkg.sv
// Shared definitions for the Sokoban game sequencer.
//   state_t      : 4-bit sequencer state encoding
//   CMD_*        : player command codes (3 is reserved and ignored)
//   SEL_*        : game-state register mux select codes
//   is_idle()    : states in which the sequencer waits on the player
package sokoban_pkg;

    typedef enum logic [3:0] {
        StReset   = 4'd0,
        StInit    = 4'd1,
        StWait    = 4'd2,
        StPause   = 4'd3,
        StOver    = 4'd4,
        StNext    = 4'd5,
        StEval    = 4'd6,
        StMove    = 4'd7,
        StRetract = 4'd8
    } state_t;

    localparam logic [1:0] CMD_MOVE  = 2'd0;
    localparam logic [1:0] CMD_RETRY = 2'd1;
    localparam logic [1:0] CMD_UNDO  = 2'd2;

    localparam logic [1:0] SEL_ROM  = 2'd0;
    localparam logic [1:0] SEL_MOVE = 2'd1;
    localparam logic [1:0] SEL_HIST = 2'd3;

    function automatic logic is_idle(input state_t st);
        return (st == StWait) || (st == StPause) || (st == StOver);
    endfunction

endpackage

// File: rtl/sokoban_game_ctrl_p_if.sv
// Move-evaluation handshake between the game sequencer and the move engine.
//   eval_req  : 1-cycle pulse starting an evaluation (sequencer -> engine)
//   eval_done : 1-cycle pulse, evaluation finished   (engine -> sequencer)
//   eval_ok   : move is legal, valid with eval_done  (engine -> sequencer)
interface sokoban_game_ctrl_p_if;
    logic eval_req;
    logic eval_done;
    logic eval_ok;

    modport master (output eval_req, input eval_done, input eval_ok);
    modport slave  (input eval_req, output eval_done, output eval_ok);
endinterface

// File: rtl/sokoban_sat_counter.sv
// Up/down counter that saturates at MAX and floors at zero.
//   clk, reset : clock, synchronous active-high reset (count -> 0)
//   clr        : synchronous clear, same effect as reset
//   inc, dec   : count up / down; both together hold the value
//   count      : current value
module sokoban_sat_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MAX   = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && !dec) begin
            if (count != MaxVal) count <= count + WIDTH'(1);
        end else if (dec && !inc) begin
            if (count != '0) count <= count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/sokoban_game_ctrl_p.sv
// Top-level Sokoban game sequencer.
//   clk, reset, restart_game : clock, sync active-high reset, sync restart (same effect)
//   confirm                  : player confirm pulse, advances past a cleared stage
//   cmd_valid, cmd, in_area  : player command (move/retry/undo) and cursor-in-board flag
//   box_map, dest_map        : board occupancy and destinations; equal means solved
//   eval_if (master)         : req/done handshake to the move-evaluation engine
//   state_load, load_sel     : game-state register enable and mux select
//   hist_push, hist_pop      : history buffer control
//   stage_idx, stage_up      : current stage and 1-cycle advance pulse
//   stage_clear, win         : stage solved (awaiting confirm) / game complete
//   step_count, undo_cnt     : steps on this stage, undos available
//   busy                     : sequencer not waiting on the player
module sokoban_game_ctrl_p
    import sokoban_pkg::*;
#(
    parameter int unsigned CELLS      = 64,
    parameter int unsigned NUM_STAGES = 4,
    parameter int unsigned STAGE_W    = 2,
    parameter int unsigned STEP_W     = 10,
    parameter int unsigned UNDO_DEPTH = 8,
    parameter int unsigned UNDO_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               restart_game,
    input  logic               confirm,
    input  logic               cmd_valid,
    input  logic [1:0]         cmd,
    input  logic               in_area,
    input  logic [CELLS-1:0]   box_map,
    input  logic [CELLS-1:0]   dest_map,
    sokoban_game_ctrl_p_if.master eval_if,
    output logic               state_load,
    output logic [1:0]         load_sel,
    output logic [STAGE_W-1:0] stage_idx,
    output logic               stage_up,
    output logic               win,
    output logic               stage_clear,
    output logic [STEP_W-1:0]  step_count,
    output logic [UNDO_W-1:0]  undo_cnt,
    output logic               hist_push,
    output logic               hist_pop,
    output logic               busy
);

    localparam logic [STAGE_W-1:0] LastStage = STAGE_W'(NUM_STAGES - 1);

    state_t state_q, state_d;
    logic   eval_req_q;

    assign eval_if.eval_req = eval_req_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StReset: state_d = StInit;
            StInit:  state_d = StWait;
            StWait: begin
                // A solved board wins over any command in the same cycle.
                if (box_map == dest_map) begin
                    state_d = (stage_idx == LastStage) ? StOver : StPause;
                end else if (cmd_valid) begin
                    if (cmd == CMD_RETRY) begin
                        state_d = StInit;
                    end else if (cmd == CMD_UNDO && undo_cnt != '0) begin
                        state_d = StRetract;
                    end else if (cmd == CMD_MOVE && in_area) begin
                        state_d = StEval;
                    end
                end
            end
            StEval: begin
                if (eval_if.eval_done) state_d = eval_if.eval_ok ? StMove : StWait;
            end
            StMove:    state_d = StWait;
            StRetract: state_d = StWait;
            StPause:   if (confirm) state_d = StNext;
            StNext:    state_d = StInit;
            StOver:    state_d = StOver;
            default:   state_d = StReset;
        endcase
        if (reset || restart_game) state_d = StReset;
    end

    // Outputs are registered alongside the state so each one is a pure
    // function of the state the sequencer is in during that cycle.
    always_ff @(posedge clk) begin
        state_q     <= state_d;
        eval_req_q  <= (state_q == StWait) && (state_d == StEval);
        state_load  <= (state_d == StReset) || (state_d == StInit) ||
                       (state_d == StMove) || (state_d == StRetract);
        load_sel    <= (state_d == StMove)    ? SEL_MOVE :
                       (state_d == StRetract) ? SEL_HIST : SEL_ROM;
        hist_push   <= (state_d == StMove);
        hist_pop    <= (state_d == StRetract);
        stage_up    <= (state_d == StNext);
        stage_clear <= (state_d == StPause);
        win         <= (state_d == StOver);
        busy        <= !is_idle(state_d);
        if (state_d == StReset) begin
            stage_idx <= '0;
        end else if (state_d == StNext) begin
            stage_idx <= stage_idx + STAGE_W'(1);
        end
    end

    // Counters act on the registered state, so MOVE/RETRACT results are
    // visible from the following WAIT cycle.
    logic cnt_rst, cnt_clr, cnt_inc, cnt_dec;

    assign cnt_rst = reset || restart_game;
    assign cnt_clr = (state_q == StInit) || (state_q == StReset);
    assign cnt_inc = (state_q == StMove);
    assign cnt_dec = (state_q == StRetract);

    sokoban_sat_counter #(
        .WIDTH (STEP_W),
        .MAX   ((2 ** STEP_W) - 1)
    ) u_step_cnt (
        .clk   (clk),
        .reset (cnt_rst),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .dec   (cnt_dec),
        .count (step_count)
    );

    // Saturating at UNDO_DEPTH mirrors the history ring overwriting its oldest entry.
    sokoban_sat_counter #(
        .WIDTH (UNDO_W),
        .MAX   (UNDO_DEPTH)
    ) u_undo_cnt (
        .clk   (clk),
        .reset (cnt_rst),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .dec   (cnt_dec),
        .count (undo_cnt)
    );

endmodule

// File: tb/tb_sokoban_game_ctrl_p.sv
// Self-checking bench for sokoban_game_ctrl_p with a behavioural game model.
module tb_sokoban_game_ctrl_p;

    localparam int CELLS = 64;
    localparam int UNDO_DEPTH = 8;
    localparam int STEP_MAX = 1023;

    logic             clk = 1'b0;
    logic             reset, restart_game, confirm, cmd_valid, in_area;
    logic [1:0]       cmd;
    logic [CELLS-1:0] box_map, dest_map;
    logic             state_load, stage_up, win, stage_clear, hist_push, hist_pop, busy;
    logic [1:0]       load_sel, stage_idx;
    logic [9:0]       step_count;
    logic [3:0]       undo_cnt;

    sokoban_game_ctrl_p_if eval_if ();

    sokoban_game_ctrl_p dut (
        .clk          (clk),
        .reset        (reset),
        .restart_game (restart_game),
        .confirm      (confirm),
        .cmd_valid    (cmd_valid),
        .cmd          (cmd),
        .in_area      (in_area),
        .box_map      (box_map),
        .dest_map     (dest_map),
        .eval_if      (eval_if),
        .state_load   (state_load),
        .load_sel     (load_sel),
        .stage_idx    (stage_idx),
        .stage_up     (stage_up),
        .win          (win),
        .stage_clear  (stage_clear),
        .step_count   (step_count),
        .undo_cnt     (undo_cnt),
        .hist_push    (hist_push),
        .hist_pop     (hist_pop),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    // Game model
    int exp_steps = 0;
    int exp_undo  = 0;
    int exp_stage = 0;
    int pops      = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_unsolved;
        box_map  = {$urandom, $urandom};
        dest_map = box_map ^ (64'd1 << $urandom_range(63, 0));
    endtask

    task automatic check_counters(input string name);
        checks++;
        if (step_count !== 10'(exp_steps) || undo_cnt !== 4'(exp_undo) || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: steps=%0d undo=%0d busy=%b, expected steps=%0d undo=%0d busy=0",
                     name, step_count, undo_cnt, busy, exp_steps, exp_undo);
        end
    endtask

    task automatic do_move(input bit ok, input int lat);
        cmd_valid = 1'b1; cmd = 2'd0; in_area = 1'b1;
        tick;
        cmd_valid = 1'b0; in_area = 1'($urandom);
        checks++;
        if (eval_if.eval_req !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL eval_req_start: eval_req=%b busy=%b, expected 1 1",
                     eval_if.eval_req, busy);
        end
        for (int i = 0; i < lat; i++) begin
            cmd_valid = 1'($urandom); cmd = 2'($urandom);
            tick;
            checks++;
            if (eval_if.eval_req !== 1'b0 || busy !== 1'b1 || state_load !== 1'b0) begin
                errors++;
                $display("FAIL eval_wait: eval_req=%b busy=%b load=%b, expected 0 1 0",
                         eval_if.eval_req, busy, state_load);
            end
        end
        cmd_valid = 1'b0;
        eval_if.eval_done = 1'b1; eval_if.eval_ok = ok;
        tick;
        eval_if.eval_done = 1'b0; eval_if.eval_ok = 1'($urandom);
        checks++;
        if (hist_push !== ok || state_load !== ok || (ok && load_sel !== 2'd1)) begin
            errors++;
            $display("FAIL move_commit: push=%b load=%b sel=%0d, expected push=%b load=%b sel=1",
                     hist_push, state_load, load_sel, ok, ok);
        end
        if (ok) begin
            exp_steps = (exp_steps < STEP_MAX) ? exp_steps + 1 : STEP_MAX;
            exp_undo  = (exp_undo < UNDO_DEPTH) ? exp_undo + 1 : UNDO_DEPTH;
            tick;
        end
        check_counters("move_counters");
    endtask

    task automatic do_undo;
        bit exp_pop;
        exp_pop = (exp_undo > 0);
        cmd_valid = 1'b1; cmd = 2'd2; in_area = 1'($urandom);
        tick;
        cmd_valid = 1'b0;
        checks++;
        if (hist_pop !== exp_pop || state_load !== exp_pop || (exp_pop && load_sel !== 2'd3)) begin
            errors++;
            $display("FAIL undo_pop: pop=%b load=%b sel=%0d, expected pop=%b load=%b sel=3",
                     hist_pop, state_load, load_sel, exp_pop, exp_pop);
        end
        if (hist_pop === 1'b1) pops++;
        if (exp_pop) begin
            exp_undo--;
            exp_steps = (exp_steps > 0) ? exp_steps - 1 : 0;
        end
        tick;
        check_counters("undo_counters");
    endtask

    task automatic do_retry;
        cmd_valid = 1'b1; cmd = 2'd1;
        tick;
        cmd_valid = 1'b0;
        checks++;
        if (state_load !== 1'b1 || load_sel !== 2'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL retry_init: load=%b sel=%0d busy=%b, expected 1 0 1",
                     state_load, load_sel, busy);
        end
        exp_steps = 0; exp_undo = 0;
        tick;
        check_counters("retry_counters");
    endtask

    task automatic do_ignored(input logic [1:0] c, input bit area);
        cmd_valid = 1'b1; cmd = c; in_area = area;
        tick;
        cmd_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || state_load !== 1'b0 || eval_if.eval_req !== 1'b0) begin
            errors++;
            $display("FAIL ignored_cmd: busy=%b load=%b req=%b, expected 0 0 0 (cmd=%0d area=%b)",
                     busy, state_load, eval_if.eval_req, c, area);
        end
        tick;
        check_counters("ignored_counters");
    endtask

    // Solve the current stage with a retry command in the same cycle (board wins).
    task automatic solve_stage;
        dest_map = box_map;
        cmd_valid = 1'b1; cmd = 2'd1;
        tick;
        checks++;
        if (exp_stage == 3) begin
            if (win !== 1'b1 || stage_clear !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL solve_last: win=%b clear=%b busy=%b, expected 1 0 0",
                         win, stage_clear, busy);
            end
            cmd_valid = 1'b0;
            return;
        end
        if (stage_clear !== 1'b1 || busy !== 1'b0 || win !== 1'b0) begin
            errors++;
            $display("FAIL solve_pause: clear=%b busy=%b win=%b, expected 1 0 0",
                     stage_clear, busy, win);
        end
        cmd = 2'($urandom);
        tick;
        cmd_valid = 1'b0;
        checks++;
        if (stage_clear !== 1'b1 || state_load !== 1'b0) begin
            errors++;
            $display("FAIL pause_hold: clear=%b load=%b, expected 1 0", stage_clear, state_load);
        end
        confirm = 1'b1;
        tick;
        confirm = 1'b0;
        set_unsolved;
        checks++;
        if (stage_up !== 1'b1 || stage_idx !== 2'(exp_stage + 1) || stage_clear !== 1'b0) begin
            errors++;
            $display("FAIL stage_up: up=%b idx=%0d clear=%b, expected 1 %0d 0",
                     stage_up, stage_idx, stage_clear, exp_stage + 1);
        end
        exp_stage++;
        tick;
        checks++;
        if (stage_up !== 1'b0 || state_load !== 1'b1) begin
            errors++;
            $display("FAIL stage_init: up=%b load=%b, expected 0 1", stage_up, state_load);
        end
        exp_steps = 0; exp_undo = 0;
        tick;
        check_counters("stage_counters");
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        checks++;
        if (state_load !== 1'b1 || load_sel !== 2'd0 || busy !== 1'b1 || stage_idx !== 2'd0 ||
            win !== 1'b0 || stage_clear !== 1'b0 || hist_push !== 1'b0 || hist_pop !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: load=%b sel=%0d busy=%b idx=%0d win=%b clear=%b",
                     state_load, load_sel, busy, stage_idx, win, stage_clear);
        end
        tick;
        checks++;
        if (state_load !== 1'b1 || load_sel !== 2'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_init: load=%b sel=%0d busy=%b, expected 1 0 1",
                     state_load, load_sel, busy);
        end
        tick;
        checks++;
        if (state_load !== 1'b0 || stage_idx !== 2'd0) begin
            errors++;
            $display("FAIL reset_wait: load=%b idx=%0d, expected 0 0", state_load, stage_idx);
        end
        exp_steps = 0; exp_undo = 0; exp_stage = 0;
        check_counters("reset_counters");
    endtask

    task automatic test_move;
        do_move(1'b1, 3);
        do_move(1'b0, 3);
        do_ignored(2'd0, 1'b0);
        do_ignored(2'd3, 1'b1);
    endtask

    task automatic test_undo_saturation;
        do_retry;
        for (int i = 0; i < 10; i++) do_move(1'b1, 1 + (i % 3));
        pops = 0;
        for (int i = 0; i < 9; i++) do_undo;
        checks++;
        if (pops != 8 || step_count !== 10'd2 || undo_cnt !== 4'd0) begin
            errors++;
            $display("FAIL undo_saturation: pops=%0d steps=%0d undo=%0d, expected 8 2 0",
                     pops, step_count, undo_cnt);
        end
    endtask

    task automatic test_stage_clear;
        solve_stage;
        do_move(1'b1, 2);
        solve_stage;
    endtask

    task automatic test_game_over;
        while (exp_stage < 3) solve_stage;
        do_move(1'b1, 1);
        solve_stage;
        for (int i = 0; i < 6; i++) begin
            confirm = 1'($urandom); cmd_valid = 1'($urandom); cmd = 2'($urandom);
            in_area = 1'($urandom); set_unsolved;
            tick;
            checks++;
            if (win !== 1'b1 || stage_idx !== 2'd3 || state_load !== 1'b0 || busy !== 1'b0 ||
                stage_up !== 1'b0) begin
                errors++;
                $display("FAIL over_hold: win=%b idx=%0d load=%b busy=%b up=%b",
                         win, stage_idx, state_load, busy, stage_up);
            end
        end
        confirm = 1'b0; cmd_valid = 1'b0;
        restart_game = 1'b1;
        tick;
        restart_game = 1'b0;
        checks++;
        if (win !== 1'b0 || stage_idx !== 2'd0 || state_load !== 1'b1 || load_sel !== 2'd0) begin
            errors++;
            $display("FAIL restart: win=%b idx=%0d load=%b sel=%0d, expected 0 0 1 0",
                     win, stage_idx, state_load, load_sel);
        end
        tick;
        tick;
        exp_steps = 0; exp_undo = 0; exp_stage = 0;
        check_counters("restart_counters");
    endtask

    task automatic test_reset_in_eval;
        int pushes = 0;
        do_move(1'b1, 1);
        cmd_valid = 1'b1; cmd = 2'd0; in_area = 1'b1;
        tick;
        cmd_valid = 1'b0;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        eval_if.eval_done = 1'b1; eval_if.eval_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            eval_if.eval_done = 1'b0;
            if (hist_push === 1'b1) pushes++;
        end
        exp_steps = 0; exp_undo = 0; exp_stage = 0;
        checks++;
        if (pushes != 0 || stage_idx !== 2'd0) begin
            errors++;
            $display("FAIL stray_done: pushes=%0d idx=%0d, expected 0 0", pushes, stage_idx);
        end
        check_counters("stray_counters");
    endtask

    task automatic test_random;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(5, 0))
                0, 1:    do_move(1'($urandom), $urandom_range(5, 1));
                2:       do_undo;
                3:       if ($urandom_range(3, 0) == 0) do_retry; else do_undo;
                4:       do_ignored(2'd0, 1'b0);
                default: do_ignored(2'd3, 1'($urandom));
            endcase
        end
    endtask

    initial begin
        reset = 1'b0; restart_game = 1'b0; confirm = 1'b0;
        cmd_valid = 1'b0; cmd = 2'd0; in_area = 1'b0;
        eval_if.eval_done = 1'b0; eval_if.eval_ok = 1'b0;
        set_unsolved;
        tick;
        test_reset;
        test_move;
        test_undo_saturation;
        test_stage_clear;
        test_game_over;
        test_reset_in_eval;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
